// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// npu_pkg : shared types and constants for the NPU convolution control path
// Revision 1.0 : initial release
// ============================================================================
package npu_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 18;

    // Free FIFO entries needed before issue: the in-flight tap plus the result push.
    localparam int OUT_READY_MARGIN   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_window_cnt.sv
`default_nettype none
// ============================================================================
// conv_window_cnt : nested window/tap counter with incremental SRAM addressing
// Revision 1.0 : initial release
// ============================================================================
module conv_window_cnt
    import npu_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] img_col,
    input  logic [ADDR_WIDTH-1:0] k_r_max,
    input  logic [ADDR_WIDTH-1:0] k_c_max,
    input  logic [ADDR_WIDTH-1:0] out_r_max,
    input  logic [ADDR_WIDTH-1:0] out_c_max,
    output logic [ADDR_WIDTH-1:0] img_addr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  first_tap,
    output logic                  last_tap,
    output logic                  last_win
);

    localparam logic [ADDR_WIDTH-1:0] C_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_k_c;
    logic [ADDR_WIDTH-1:0] r_k_r;
    logic [ADDR_WIDTH-1:0] r_out_c;
    logic [ADDR_WIDTH-1:0] r_out_r;
    logic [ADDR_WIDTH-1:0] r_line_base;   // out_r * img_col
    logic [ADDR_WIDTH-1:0] r_win_base;    // line_base + out_c
    logic [ADDR_WIDTH-1:0] r_row_base;    // win_base + k_r * img_col
    logic [ADDR_WIDTH-1:0] r_img_addr;
    logic [ADDR_WIDTH-1:0] r_w_addr;

    logic                  w_kc_end;
    logic                  w_kr_end;
    logic                  w_oc_end;
    logic                  w_or_end;
    logic [ADDR_WIDTH-1:0] w_row_step;
    logic [ADDR_WIDTH-1:0] w_line_step;
    logic [ADDR_WIDTH-1:0] w_win_inc;

    assign w_kc_end    = (r_k_c   == k_c_max);
    assign w_kr_end    = (r_k_r   == k_r_max);
    assign w_oc_end    = (r_out_c == out_c_max);
    assign w_or_end    = (r_out_r == out_r_max);
    assign w_row_step  = r_row_base  + img_col;
    assign w_line_step = r_line_base + img_col;
    assign w_win_inc   = r_win_base  + C_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_c       <= '0;
            r_k_r       <= '0;
            r_out_c     <= '0;
            r_out_r     <= '0;
            r_line_base <= '0;
            r_win_base  <= '0;
            r_row_base  <= '0;
            r_img_addr  <= '0;
            r_w_addr    <= '0;
        end else if (clear) begin
            r_k_c       <= '0;
            r_k_r       <= '0;
            r_out_c     <= '0;
            r_out_r     <= '0;
            r_line_base <= '0;
            r_win_base  <= '0;
            r_row_base  <= '0;
            r_img_addr  <= '0;
            r_w_addr    <= '0;
        end else if (advance) begin
            if (!w_kc_end) begin
                r_k_c      <= r_k_c + C_ONE;
                r_img_addr <= r_img_addr + C_ONE;
                r_w_addr   <= r_w_addr + C_ONE;
            end else if (!w_kr_end) begin
                r_k_c      <= '0;
                r_k_r      <= r_k_r + C_ONE;
                r_row_base <= w_row_step;
                r_img_addr <= w_row_step;
                r_w_addr   <= r_w_addr + C_ONE;
            end else begin
                // Window finished: weights restart, image moves to the next window origin.
                r_k_c    <= '0;
                r_k_r    <= '0;
                r_w_addr <= '0;
                if (!w_oc_end) begin
                    r_out_c    <= r_out_c + C_ONE;
                    r_win_base <= w_win_inc;
                    r_row_base <= w_win_inc;
                    r_img_addr <= w_win_inc;
                end else if (!w_or_end) begin
                    r_out_c     <= '0;
                    r_out_r     <= r_out_r + C_ONE;
                    r_line_base <= w_line_step;
                    r_win_base  <= w_line_step;
                    r_row_base  <= w_line_step;
                    r_img_addr  <= w_line_step;
                end else begin
                    r_out_c     <= '0;
                    r_out_r     <= '0;
                    r_line_base <= '0;
                    r_win_base  <= '0;
                    r_row_base  <= '0;
                    r_img_addr  <= '0;
                end
            end
        end
    end

    assign img_addr  = r_img_addr;
    assign w_addr    = r_w_addr;
    assign first_tap = (r_k_c == '0) && (r_k_r == '0);
    assign last_tap  = w_kc_end && w_kr_end;
    assign last_win  = w_oc_end && w_or_end;

endmodule
`default_nettype wire

// File: rtl/conv_window_sched.sv
`default_nettype none
// ============================================================================
// conv_window_sched : convolution window sequencer driving SRAM reads and MAC control
// Revision 1.0 : initial release
// ============================================================================
module conv_window_sched
    import npu_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] img_row,
    input  logic [ADDR_WIDTH-1:0] img_col,
    input  logic [ADDR_WIDTH-1:0] ker_row,
    input  logic [ADDR_WIDTH-1:0] ker_col,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] img_rd_addr,
    output logic [ADDR_WIDTH-1:0] w_rd_addr,
    output logic                  rd_en,
    output logic                  mac_valid,
    output logic                  mac_clear,
    output logic                  mac_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] C_ONE = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_img_row;
    logic [ADDR_WIDTH-1:0] r_img_col;
    logic [ADDR_WIDTH-1:0] r_ker_row;
    logic [ADDR_WIDTH-1:0] r_ker_col;

    logic                  r_mac_valid;
    logic                  r_mac_clear;
    logic                  r_mac_last;
    logic                  r_done;

    logic                  w_illegal;
    logic                  w_rd_en;
    logic                  w_err;
    logic                  w_busy;
    logic                  w_cnt_clear;
    logic                  w_first_tap;
    logic                  w_last_tap;
    logic                  w_last_win;
    logic [ADDR_WIDTH-1:0] w_img_addr;
    logic [ADDR_WIDTH-1:0] w_w_addr;

    assign w_illegal = (r_img_row == '0) || (r_img_col == '0) ||
                       (r_ker_row == '0) || (r_ker_col == '0) ||
                       (r_ker_row > r_img_row) || (r_ker_col > r_img_col);

    // Dimensions are captured only when a start is accepted in IDLE.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_img_row <= '0;
            r_img_col <= '0;
            r_ker_row <= '0;
            r_ker_col <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_img_row <= img_row;
            r_img_col <= img_col;
            r_ker_row <= ker_row;
            r_ker_col <= ker_col;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_err        = 1'b0;
        w_busy       = 1'b0;
        w_cnt_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (w_illegal) begin
                    w_err        = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_busy       = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy  = 1'b1;
                w_rd_en = out_ready;
                if (out_ready && w_last_tap && w_last_win) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_busy       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    conv_window_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cnt (
        .clk       (s00_axis_aclk),
        .rst       (s00_axis_areset),
        .clear     (w_cnt_clear),
        .advance   (w_rd_en),
        .img_col   (r_img_col),
        .k_r_max   (r_ker_row - C_ONE),
        .k_c_max   (r_ker_col - C_ONE),
        .out_r_max (r_img_row - r_ker_row),
        .out_c_max (r_img_col - r_ker_col),
        .img_addr  (w_img_addr),
        .w_addr    (w_w_addr),
        .first_tap (w_first_tap),
        .last_tap  (w_last_tap),
        .last_win  (w_last_win)
    );

    // MAC controls track the one-cycle SRAM read latency and never stall.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_mac_valid <= 1'b0;
            r_mac_clear <= 1'b0;
            r_mac_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mac_valid <= w_rd_en;
            r_mac_clear <= w_rd_en && w_first_tap;
            r_mac_last  <= w_rd_en && w_last_tap;
            r_done      <= (r_state == DRAIN);
        end
    end

    assign img_rd_addr = w_img_addr;
    assign w_rd_addr   = w_w_addr;
    assign rd_en       = w_rd_en;
    assign mac_valid   = r_mac_valid;
    assign mac_clear   = r_mac_clear;
    assign mac_last    = r_mac_last;
    assign busy        = w_busy;
    assign done        = r_done;
    assign err         = w_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sched.sv
`default_nettype none
// ============================================================================
// tb_conv_window_sched : self-checking bench with a tap-list reference model
// Revision 1.0 : initial release
// ============================================================================
module tb_conv_window_sched;
    import npu_pkg::*;

    localparam int AW = 18;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] img_row;
    logic [AW-1:0] img_col;
    logic [AW-1:0] ker_row;
    logic [AW-1:0] ker_col;
    logic          out_ready;
    logic [AW-1:0] img_rd_addr;
    logic [AW-1:0] w_rd_addr;
    logic          rd_en;
    logic          mac_valid;
    logic          mac_clear;
    logic          mac_last;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;

    conv_window_sched #(.ADDR_WIDTH(AW)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .start           (start),
        .img_row         (img_row),
        .img_col         (img_col),
        .ker_row         (ker_row),
        .ker_col         (ker_col),
        .out_ready       (out_ready),
        .img_rd_addr     (img_rd_addr),
        .w_rd_addr       (w_rd_addr),
        .rd_en           (rd_en),
        .mac_valid       (mac_valid),
        .mac_clear       (mac_clear),
        .mac_last        (mac_last),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: always ready, 1: random FIFO space, 2: 5-cycle stall after 5 taps,
    // 3: always ready with a second start pulse during RUN
    task automatic run_case(input int ir, input int ic, input int kr, input int kc, input int mode,
                            output int taps_seen, output int lasts_seen, output int errs_seen,
                            output int done_cyc);
        int  qi[$];
        int  qw[$];
        bit  qf[$];
        bit  ql[$];
        bit  legal;
        bit  ready;
        bit  exp_rd;
        bit  prev_rd;
        bit  prev_f;
        bit  prev_l;
        int  n;
        int  idx;
        int  last_issue;
        int  stall_left;
        int  bound;

        legal = (ir > 0) && (ic > 0) && (kr > 0) && (kc > 0) && (kr <= ir) && (kc <= ic);
        if (legal) begin
            for (int orow = 0; orow <= ir - kr; orow++)
                for (int ocol = 0; ocol <= ic - kc; ocol++)
                    for (int a = 0; a < kr; a++)
                        for (int b = 0; b < kc; b++) begin
                            qi.push_back(((orow + a) * ic + ocol + b) % (1 << AW));
                            qw.push_back(a * kc + b);
                            qf.push_back((a == 0) && (b == 0));
                            ql.push_back((a == kr - 1) && (b == kc - 1));
                        end
        end
        n          = qi.size();
        idx        = 0;
        prev_rd    = 1'b0;
        prev_f     = 1'b0;
        prev_l     = 1'b0;
        last_issue = -1;
        stall_left = 0;
        bound      = 8 * n + 40;
        taps_seen  = 0;
        lasts_seen = 0;
        errs_seen  = 0;
        done_cyc   = -1;

        for (int cyc = 0; ; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 0) || ((mode == 3) && (cyc == 6));
            if (cyc == 0) begin
                img_row = AW'(ir);
                img_col = AW'(ic);
                ker_row = AW'(kr);
                ker_col = AW'(kc);
            end else if (start) begin
                img_row = AW'(2);
                img_col = AW'(2);
                ker_row = AW'(1);
                ker_col = AW'(1);
            end
            case (mode)
                1: ready = ($urandom_range(0, 4) >= OUT_READY_MARGIN);
                2: begin
                    if (stall_left > 0) begin
                        ready = 1'b0;
                        stall_left--;
                    end else begin
                        ready = 1'b1;
                    end
                end
                default: ready = 1'b1;
            endcase
            out_ready = ready;
            exp_rd = legal && (cyc >= 2) && (idx < n) && ready;

            @(negedge clk);
            check("rd_en", rd_en, exp_rd);
            check("err", err, !legal && (cyc == 1));
            check("busy", busy, legal && (cyc >= 1) && ((last_issue < 0) || (cyc <= last_issue + 1)));
            check("done", done, legal && (last_issue >= 0) && (cyc == last_issue + 2));
            check("mac_valid", mac_valid, prev_rd);
            check("mac_clear", mac_clear, prev_rd && prev_f);
            check("mac_last", mac_last, prev_rd && prev_l);

            taps_seen  += int'(rd_en);
            lasts_seen += int'(mac_valid && mac_last);
            errs_seen  += int'(err);
            if (done && (done_cyc < 0)) done_cyc = cyc;

            if (exp_rd) begin
                check("img_rd_addr", img_rd_addr, qi[idx]);
                check("w_rd_addr", w_rd_addr, qw[idx]);
                prev_f = qf[idx];
                prev_l = ql[idx];
                idx++;
                if (idx == n) last_issue = cyc;
                if ((mode == 2) && (idx == 5)) stall_left = 5;
            end else begin
                prev_f = 1'b0;
                prev_l = 1'b0;
            end
            prev_rd = exp_rd;

            if (!legal && (cyc == 2)) break;
            if (legal && (last_issue >= 0) && (cyc == last_issue + 2)) break;
            if (cyc > bound) begin
                check("run_timeout", 1, 0);
                break;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    typedef struct {
        int ir;
        int ic;
        int kr;
        int kc;
        int mode;
        int taps;
        int lasts;
        int errs;
        int done_at;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int taps;
        int lasts;
        int errs;
        int dcyc;
        int seen;

        vecs[0]  = '{4, 4, 3, 3, 0, 36,  4, 0, 39};
        vecs[1]  = '{3, 3, 1, 1, 0,  9,  9, 0, 12};
        vecs[2]  = '{4, 4, 5, 5, 0,  0,  0, 1, -1};
        vecs[3]  = '{4, 4, 3, 0, 0,  0,  0, 1, -1};
        vecs[4]  = '{4, 4, 3, 3, 2, 36,  4, 0, 44};
        vecs[5]  = '{5, 6, 2, 3, 0, 96, 16, 0, 99};
        vecs[6]  = '{1, 1, 1, 1, 0,  1,  1, 0,  4};
        vecs[7]  = '{0, 4, 1, 1, 0,  0,  0, 1, -1};
        vecs[8]  = '{3, 7, 3, 2, 1, 36,  6, 0, -1};
        vecs[9]  = '{4, 4, 3, 3, 3, 36,  4, 0, 39};
        vecs[10] = '{6, 2, 2, 3, 0,  0,  0, 1, -1};
        vecs[11] = '{2, 5, 2, 5, 0, 10,  1, 0, 13};

        rst       = 1'b1;
        start     = 1'b0;
        img_row   = '0;
        img_col   = '0;
        ker_row   = '0;
        ker_col   = '0;
        out_ready = 1'b1;
        #12;
        check("reset_outputs", {img_rd_addr, w_rd_addr, rd_en, mac_valid, mac_clear,
                                mac_last, busy, done, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_case(vecs[i].ir, vecs[i].ic, vecs[i].kr, vecs[i].kc, vecs[i].mode,
                     taps, lasts, errs, dcyc);
            check($sformatf("vec%0d_taps", i), taps, vecs[i].taps);
            check($sformatf("vec%0d_lasts", i), lasts, vecs[i].lasts);
            check($sformatf("vec%0d_errs", i), errs, vecs[i].errs);
            if (vecs[i].mode != 1)
                check($sformatf("vec%0d_done_cycle", i), dcyc, vecs[i].done_at);
        end

        for (int r = 0; r < 8; r++) begin
            int ir;
            int ic;
            int kr;
            int kc;
            int exp_taps;
            ir = int'($urandom_range(1, 6));
            ic = int'($urandom_range(1, 6));
            kr = int'($urandom_range(1, ir + 1));
            kc = int'($urandom_range(0, ic));
            if ((kr <= ir) && (kc >= 1))
                exp_taps = (ir - kr + 1) * (ic - kc + 1) * kr * kc;
            else
                exp_taps = 0;
            run_case(ir, ic, kr, kc, 1, taps, lasts, errs, dcyc);
            check("rand_taps", taps, exp_taps);
            check("rand_errs", errs, (exp_taps == 0) ? 1 : 0);
        end

        // Asynchronous reset in the middle of a run.
        @(posedge clk);
        #1;
        img_row   = AW'(4);
        img_col   = AW'(4);
        ker_row   = AW'(3);
        ker_col   = AW'(3);
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 0;
        for (int c = 0; (c < 40) && (seen < 10); c++) begin
            @(negedge clk);
            if (rd_en) seen++;
        end
        check("pre_reset_taps", seen, 10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {img_rd_addr, w_rd_addr, rd_en, mac_valid, mac_clear,
                                      mac_last, busy, done, err}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_reset_idle", {rd_en, busy, done}, 0);
        end
        run_case(4, 4, 3, 3, 0, taps, lasts, errs, dcyc);
        check("after_reset_taps", taps, 36);
        check("after_reset_lasts", lasts, 4);
        check("after_reset_done_cycle", dcyc, 39);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_window_sched.md
# conv_window_sched

Sequencer for the NPU convolution datapath. After image and kernel have been loaded into their SRAMs, it walks every valid (stride-1, no-padding) output window in row-major order. For each window it issues image and weight SRAM read addresses one tap per cycle and drives the MAC array's clear, valid and last controls. It sits between the AXI-Stream load logic, which supplies the dimensions from tuser, and the MAC array and output FIFO that feed m00_axis.

## Interface
- ADDR_WIDTH, 18: width of dimensions and SRAM addresses.
- s00_axis_aclk  in  1: single clock.
- s00_axis_areset  in  1: asynchronous, active-high reset.
- start  in  1: one-cycle pulse; begin a convolution with the dimensions below.
- img_row, img_col  in  ADDR_WIDTH: image dimensions; sampled on an accepted start.
- ker_row, ker_col  in  ADDR_WIDTH: kernel dimensions; sampled on an accepted start.
- out_ready  in  1: output FIFO has at least 2 free entries; low stalls issue.
- img_rd_addr  out  ADDR_WIDTH: image SRAM read address.
- w_rd_addr  out  ADDR_WIDTH: weight SRAM read address.
- rd_en  out  1: both SRAM reads valid this cycle.
- mac_valid  out  1: SRAM data returning this cycle; accumulate it.
- mac_clear  out  1: with mac_valid; first tap of a window; accumulator loads the product instead of adding.
- mac_last  out  1: with mac_valid; final tap of a window; the result is pushed to the FIFO next cycle.
- busy  out  1: high from an accepted start until done or err.
- done  out  1: one-cycle pulse after the final mac_last.
- err  out  1: one-cycle pulse on illegal dimensions.

## Operation
- States: IDLE, CHECK, RUN, DRAIN.
- IDLE: start latches the dimensions -> CHECK. start is ignored while busy.
- CHECK (1 cycle): illegal dimensions are any zero dimension, ker_row>img_row, or ker_col>img_col.
  - Illegal: err pulse, no rd_en -> IDLE.
  - Legal: clear counters -> RUN.
- Counters:
  - out_r in 0..img_row-ker_row; out_c in 0..img_col-ker_col.
  - k_r in 0..ker_row-1; k_c in 0..ker_col-1.
  - w_rd_addr = k_r*ker_col+k_c, kept as a linear counter reset per window.
  - img_rd_addr = (out_r+k_r)*img_col+(out_c+k_c), built incrementally from a row-base register; adders only, no multipliers.
- RUN: each cycle with out_ready=1, assert rd_en and advance k_c, then k_r, then out_c, then out_r.
  - out_ready=0: rd_en=0, all counters hold.
  - On issuing the last tap of the last window -> DRAIN.
- DRAIN (1 cycle): final mac_valid/mac_last emitted -> IDLE with a done pulse.
- Output count = (img_row-ker_row+1)*(img_col-ker_col+1); tap count = outputs*ker_row*ker_col.
- Arithmetic: all address math is modulo 2^ADDR_WIDTH; the load side guarantees img_row*img_col <= 2^ADDR_WIDTH.

## Timing
- Reset values: every output 0; state IDLE; counters 0.
- Reset mid-run aborts immediately: no done, no further rd_en.
- mac_valid, mac_clear and mac_last are rd_en, first-tap and last-tap delayed by exactly 1 cycle, matching the SRAM read latency. The delay register is not stalled.
- First rd_en occurs 2 cycles after the start cycle (start -> CHECK -> RUN).
- Unstalled: one tap per cycle; done occurs tap_count+3 cycles after start.
- out_ready is sampled in the same cycle it gates rd_en. The FIFO margin of 2 absorbs the in-flight tap plus the result push.
- 1x1 kernel: mac_clear and mac_last assert in the same cycle.
- err asserts the cycle after start; busy drops the same cycle as err or done.

## Structure
- Shared package npu_pkg holds:
  - ADDR_WIDTH default.
  - state enum {IDLE, CHECK, RUN, DRAIN}.
  - the out_ready margin constant (2).
- Optional sub-module: conv_window_cnt, the nested 4-level counter with the incremental address adder; the FSM and delay stage stay in the top.

## Test plan
- 4x4 image, 3x3 kernel, out_ready=1 -> 36 taps, 4 mac_last.
  - Window 0 img addrs 0,1,2,4,5,6,8,9,10; window 1 starts at 1; window 2 starts at 4.
  - w_rd_addr 0..8 repeated; done 39 cycles after start.
- 3x3 image, 1x1 kernel -> 9 taps, img addrs 0..8; every mac_valid has mac_clear=mac_last=1.
- 4x4 image, 5x5 kernel, then ker_col=0 -> err pulse in the cycle after start each time; rd_en never high; busy drops with err.
- 4x4/3x3 with out_ready low for 5 cycles after tap 4 -> rd_en low those 5 cycles; the address sequence resumes at addr 6 with no skip or repeat; done delayed by exactly 5 cycles.
- Assert s00_axis_areset at tap 10 -> all outputs 0 asynchronously, state IDLE, no done. A following start completes a full, correct run.
- start pulsed again during RUN -> ignored; tap count and done timing unchanged.
